eth_baser_multilane_blk_sync: RTL

ETH_BASER_MULTILANE_BLK_SYNC -- requirements
Module: eth_baser_multilane_blk_sync

---
 rtl/eth_baser_blk_sync_pkg.sv | 27 ++
 rtl/eth_baser_blk_sync_lane.sv | 147 ++++++++++++++
 rtl/eth_baser_multilane_blk_sync.sv | 44 ++++
 3 files changed

// File: rtl/eth_baser_blk_sync_pkg.sv
// Shared types and constants for the multi-lane 10GBASE-R style block lock.
// Lock-state encoding, valid sync headers and counter widths used by every lane.
package eth_baser_blk_sync_pkg;

  typedef enum logic [2:0] {
    ST_RESET_CNT,
    ST_TEST_SH,
    ST_SLIP,
    ST_SLIP_WAIT,
    ST_LOCKED
  } lock_state_e;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int unsigned SH_CNT_W     = 8;
  localparam int unsigned SLIP_CNT_W   = 8;
  localparam int unsigned BER_ERR_W    = 8;
  localparam int unsigned BER_TMR_W    = 16;
  localparam int unsigned BER_COUNT_W  = 6;
  localparam int unsigned WINDOW_BEATS = 64;

  function automatic logic sh_valid(input logic [1:0] hdr);
    return (hdr == SH_DATA) || (hdr == SH_CTRL);
  endfunction

endpackage

// File: rtl/eth_baser_blk_sync_lane.sv
// One receive lane: sync-header lock FSM, hi-BER monitor and saturating
// invalid-header counter.
module eth_baser_blk_sync_lane
  import eth_baser_blk_sync_pkg::*;
#(
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_BAD = 16,
  parameter int SLIP_WAIT  = 32,
  parameter int BER_WINDOW = 19531,
  parameter int BER_THRESH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [1:0]             rx_sync_hdr,
  input  logic                   ber_cnt_clr,
  output logic                   rx_blk_slip,
  output logic                   rx_blk_lock,
  output logic                   rx_hi_ber,
  output logic [BER_COUNT_W-1:0] ber_count
);

  localparam logic [SH_CNT_W-1:0]   LOCK_CNT_V  = SH_CNT_W'(LOCK_CNT);
  localparam logic [SH_CNT_W-1:0]   UNLOCK_V    = SH_CNT_W'(UNLOCK_BAD);
  localparam logic [SH_CNT_W-1:0]   WINDOW_V    = SH_CNT_W'(WINDOW_BEATS);
  localparam logic [SLIP_CNT_W-1:0] SLIP_WAIT_V = SLIP_CNT_W'(SLIP_WAIT);
  localparam logic [BER_TMR_W-1:0]  BER_LAST    = BER_TMR_W'(BER_WINDOW - 1);
  localparam logic [BER_ERR_W-1:0]  BER_TH      = BER_ERR_W'(BER_THRESH);

  lock_state_e           state_q, state_d;
  logic [SH_CNT_W-1:0]   sh_cnt_q, sh_cnt_d, sh_inc;
  logic [SH_CNT_W-1:0]   bad_cnt_q, bad_cnt_d, bad_inc;
  logic [SLIP_CNT_W-1:0] slip_cnt_q, slip_cnt_d, slip_inc;
  logic [BER_TMR_W-1:0]  ber_tmr_q;
  logic [BER_ERR_W-1:0]  ber_err_q;
  logic                  hi_ber_q;
  logic                  hdr_ok;
  logic                  beat_bad;
  logic                  lock;

  assign hdr_ok   = sh_valid(rx_sync_hdr);
  assign beat_bad = rx_valid && !hdr_ok;
  assign sh_inc   = sh_cnt_q + 1'b1;
  assign bad_inc  = bad_cnt_q + 1'b1;
  assign slip_inc = slip_cnt_q + 1'b1;
  assign lock     = (state_q == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET_CNT;
      sh_cnt_q   <= '0;
      bad_cnt_q  <= '0;
      slip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    slip_cnt_d = slip_cnt_q;
    case (state_q)
      ST_RESET_CNT: begin
        sh_cnt_d  = '0;
        bad_cnt_d = '0;
        state_d   = ST_TEST_SH;
      end
      ST_TEST_SH: begin
        if (rx_valid) begin
          if (!hdr_ok) begin
            state_d = ST_SLIP;
          end else if (sh_inc == LOCK_CNT_V) begin
            state_d   = ST_LOCKED;
            sh_cnt_d  = '0;
            bad_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_inc;
          end
        end
      end
      ST_SLIP: begin
        slip_cnt_d = '0;
        state_d    = ST_SLIP_WAIT;
      end
      ST_SLIP_WAIT: begin
        if (rx_valid) begin
          if (slip_inc == SLIP_WAIT_V) state_d = ST_RESET_CNT;
          else                         slip_cnt_d = slip_inc;
        end
      end
      ST_LOCKED: begin
        // Unlock is checked before window rollover so a final-beat error still drops lock.
        if (rx_valid) begin
          if (!hdr_ok && bad_inc == UNLOCK_V) begin
            state_d = ST_SLIP;
          end else if (sh_inc == WINDOW_V) begin
            sh_cnt_d  = '0;
            bad_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_inc;
            if (!hdr_ok) bad_cnt_d = bad_inc;
          end
        end
      end
      default: state_d = ST_RESET_CNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !lock) begin
      ber_tmr_q <= '0;
      ber_err_q <= '0;
      hi_ber_q  <= 1'b0;
    end else if (ber_tmr_q == BER_LAST) begin
      // An error on the expiry cycle opens the next window's count.
      ber_tmr_q <= '0;
      ber_err_q <= BER_ERR_W'(beat_bad);
      if (ber_err_q < BER_TH) hi_ber_q <= 1'b0;
    end else begin
      ber_tmr_q <= ber_tmr_q + 1'b1;
      if (beat_bad && ber_err_q != BER_TH) begin
        ber_err_q <= ber_err_q + 1'b1;
        if (ber_err_q == BER_TH - 1'b1) hi_ber_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ber_count <= '0;
    end else if (ber_cnt_clr) begin
      ber_count <= BER_COUNT_W'(beat_bad);
    end else if (beat_bad && ber_count != '1) begin
      ber_count <= ber_count + 1'b1;
    end
  end

  assign rx_blk_slip = (state_q == ST_SLIP);
  assign rx_blk_lock = lock;
  assign rx_hi_ber   = hi_ber_q && lock;

endmodule

// File: rtl/eth_baser_multilane_blk_sync.sv
// Multi-lane 66b block synchroniser: NUM_LANES independent lane instances
// sharing only the clock and reset.
module eth_baser_multilane_blk_sync
  import eth_baser_blk_sync_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_BAD = 16,
  parameter int SLIP_WAIT  = 32,
  parameter int BER_WINDOW = 19531,
  parameter int BER_THRESH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_LANES-1:0]             rx_valid,
  input  logic [2*NUM_LANES-1:0]           rx_sync_hdr,
  input  logic [NUM_LANES-1:0]             ber_cnt_clr,
  output logic [NUM_LANES-1:0]             rx_blk_slip,
  output logic [NUM_LANES-1:0]             rx_blk_lock,
  output logic [NUM_LANES-1:0]             rx_hi_ber,
  output logic [BER_COUNT_W*NUM_LANES-1:0] ber_count
);

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    eth_baser_blk_sync_lane #(
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_BAD (UNLOCK_BAD),
      .SLIP_WAIT  (SLIP_WAIT),
      .BER_WINDOW (BER_WINDOW),
      .BER_THRESH (BER_THRESH)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .rx_valid    (rx_valid[n]),
      .rx_sync_hdr (rx_sync_hdr[2*n +: 2]),
      .ber_cnt_clr (ber_cnt_clr[n]),
      .rx_blk_slip (rx_blk_slip[n]),
      .rx_blk_lock (rx_blk_lock[n]),
      .rx_hi_ber   (rx_hi_ber[n]),
      .ber_count   (ber_count[BER_COUNT_W*n +: BER_COUNT_W])
    );
  end

endmodule
